invader_hit_detect: RTL
=======================

// Module: invader_hit_detect
// PURPOSE
// Consumer of the per-pixel sprite-row stream (spr_draw) produced by the invader row drawer.
// Detects overlap between a drawn invader pixel and the player bullet pixel.
// Latches row/column of the struck invader, clears its alive bit and hands the hit to game logic.
// Owns the alive mask that is fed back to the row drawers as their per-sprite visibility vector.
// PARAMETERS
// INVADERS_H  11  invaders per row; spr_draw encodes 1..INVADERS_H, 0 = no sprite pixel
// INVADERS_V   5  number of invader rows
// PORTS
// clk          in   1                        pixel clock
// rst_n        in   1                        async active-low reset
// frame_start  in   1                        1-cycle pulse at start of each frame (vsync edge)
// alive_init   in   1                        1-cycle pulse: restore all invaders (new wave)
// row_active   in   1                        a drawer is currently emitting spr_draw for row_sel
// row_sel      in   $clog2(INVADERS_V)       index of row being drawn, 0 = top
// spr_draw     in   $clog2(INVADERS_H)+1     drawer output, 1-based sprite index or 0
// bullet_px    in   1                        current pixel belongs to bullet; cycle-aligned with spr_draw
// hit_ready    in   1                        game logic accepts hit
// hit_valid    out  1                        hit pending
// hit_row      out  $clog2(INVADERS_V)       row of struck invader
// hit_col      out  $clog2(INVADERS_H)       column of struck invader, 0-based
// bullet_kill  out  1                        1-cycle pulse: retire bullet
// alive        out  INVADERS_V*INVADERS_H    alive mask, bit row*INVADERS_H+col
// alive_count  out  $clog2(INVADERS_V*INVADERS_H+1)  invaders remaining
// all_dead     out  1                        alive_count == 0
// BEHAVIOUR
// - Reset (rst_n low, async): state ARMED, alive all ones, alive_count = INVADERS_V*INVADERS_H,
//   hit_valid/bullet_kill/all_dead 0, hit_row/hit_col 0.
// - States: ARMED (scanning), PENDING (hit_valid high, awaiting hit_ready), LOCKED (hit accepted,
//   wait for frame_start).
// - Overlap at cycle N: state ARMED, row_active, bullet_px, 1 <= spr_draw <= INVADERS_H, and the alive bit
//   for (row_sel, spr_draw-1) is 1.
// - At N+1: hit_row/hit_col latched, alive bit cleared, alive_count decremented, bullet_kill high
//   for 1 cycle only, hit_valid high, state PENDING.
// - spr_draw > INVADERS_H, or row_sel >= INVADERS_V: no hit.
// - Overlap on a dead invader's bit: no hit. The drawer should not emit such a pixel.
// - PENDING: hit_valid and hit_row/hit_col hold until the cycle with hit_ready high.
//   - Next cycle: hit_valid 0, state LOCKED.
//   - Further overlaps are ignored. At most one hit per frame.
// - LOCKED -> ARMED on frame_start. ARMED stays ARMED on frame_start.
// - frame_start while PENDING: no effect; the lock releases on the first frame_start after the handshake.
// - Overlap in the same cycle as frame_start: ignored.
// - Overlap with hit_ready high and no hit pending: hit_ready has no effect.
// - alive_init (any state, highest priority after reset):
//   - Next cycle: alive all ones, count full, hit_valid 0, bullet_kill 0, state ARMED.
//   - Overrides a same-cycle overlap.
// - all_dead is registered: it goes high the cycle after alive_count reaches 0.
// - Count arithmetic never wraps; a decrement is only possible when the count is nonzero.
// STRUCTURE
// - The shared constants include supplies INVADERS_H, INVADERS_V and sprite enums. Add the hit-FSM state
//   localparams there only if the game controller needs them.
// - Alive-bit index (row*INVADERS_H+col) is computed in one shared function.
// - One sub-module is natural: hit_fsm (ARMED/PENDING/LOCKED sequencing + handshake).
//   The mask and count stay in the parent.
// TESTING
// 1. Reset then bullet_px with row_sel=2, spr_draw=4 -> next cycle hit_row=2, hit_col=3, alive[25]=0,
//    alive_count=54, bullet_kill 1 cycle.
// 2. Hold hit_ready=0 for 20 cycles with further overlaps (row 0, col 5) -> hit stays (2,3), alive[5] stays 1;
//    ready=1 -> hit_valid drops next cycle.
// 3. After handshake, overlap before frame_start -> ignored. Pulse frame_start, then overlap row 4, col 10
//    -> alive[54]=0.
// 4. spr_draw=12, or spr_draw=0 with bullet_px=1 -> no hit, no mask change.
// 5. Kill all 55 invaders across frames -> alive_count=0, all_dead=1. Pulse alive_init -> mask all ones,
//    count 55, all_dead 0.
// 6. Assert rst_n low while PENDING -> hit_valid 0 immediately (async), mask restored.
//    Overlap plus alive_init in the same cycle -> alive_init wins.

Source files
------------

// File: rtl/invader_hit_detect_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | invader_hit_detect_pkg : shared playfield constants and alive-bit indexing |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package invader_hit_detect_pkg;

  localparam int INVADERS_H = 11;
  localparam int INVADERS_V = 5;

  // Sprite codes on the drawer stream: 0 is background, 1..INVADERS_H name a column.
  typedef enum logic [0:0] {
    SPR_NONE    = 1'b0,
    SPR_INVADER = 1'b1
  } spr_kind_t;

  function automatic int alive_idx(input int row, input int col, input int h);
    return row * h + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/invader_hit_detect_hit_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | invader_hit_detect_hit_fsm : ARMED/PENDING/LOCKED hit sequencing          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module invader_hit_detect_hit_fsm (
  input  logic clk,
  input  logic rst_n,
  input  logic i_frame_start,
  input  logic i_alive_init,
  input  logic i_overlap,
  input  logic i_hit_ready,
  output logic o_capture,
  output logic o_hit_valid
);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_PENDING = 2'd1,
    ST_LOCKED  = 2'd2
  } hit_state_t;

  hit_state_t r_state;
  hit_state_t w_state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ARMED;
    else        r_state <= w_state_nxt;
  end

  // An overlap coinciding with frame_start or a wave restart is discarded.
  always_comb begin
    w_state_nxt = r_state;
    o_capture   = 1'b0;
    o_hit_valid = (r_state == ST_PENDING);
    if (i_alive_init) begin
      w_state_nxt = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (i_overlap && !i_frame_start) begin
            o_capture   = 1'b1;
            w_state_nxt = ST_PENDING;
          end
        end
        ST_PENDING: if (i_hit_ready)   w_state_nxt = ST_LOCKED;
        ST_LOCKED:  if (i_frame_start) w_state_nxt = ST_ARMED;
        default:    w_state_nxt = ST_ARMED;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/invader_hit_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | invader_hit_detect : bullet/invader overlap, alive mask and hit handoff   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module invader_hit_detect #(
  parameter int INVADERS_H = invader_hit_detect_pkg::INVADERS_H,
  parameter int INVADERS_V = invader_hit_detect_pkg::INVADERS_V
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        frame_start,
  input  logic                                        alive_init,
  input  logic                                        row_active,
  input  logic [$clog2(INVADERS_V)-1:0]               row_sel,
  input  logic [$clog2(INVADERS_H):0]                 spr_draw,
  input  logic                                        bullet_px,
  input  logic                                        hit_ready,
  output logic                                        hit_valid,
  output logic [$clog2(INVADERS_V)-1:0]               hit_row,
  output logic [$clog2(INVADERS_H)-1:0]               hit_col,
  output logic                                        bullet_kill,
  output logic [INVADERS_V*INVADERS_H-1:0]            alive,
  output logic [$clog2(INVADERS_V*INVADERS_H+1)-1:0]  alive_count,
  output logic                                        all_dead
);

  import invader_hit_detect_pkg::*;

  localparam int ROW_W = $clog2(INVADERS_V);
  localparam int COL_W = $clog2(INVADERS_H);
  localparam int SPR_W = COL_W + 1;
  localparam int N_INV = INVADERS_V * INVADERS_H;
  localparam int CNT_W = $clog2(N_INV + 1);
  localparam int IDX_W = $clog2(N_INV);

  logic [N_INV-1:0] r_alive;
  logic [CNT_W-1:0] r_count;
  logic             r_all_dead;
  logic [ROW_W-1:0] r_hit_row;
  logic [COL_W-1:0] r_hit_col;
  logic             r_bullet_kill;

  logic             w_spr_ok;
  logic             w_row_ok;
  logic             w_valid;
  logic [COL_W-1:0] w_col;
  logic [IDX_W-1:0] w_idx;
  logic             w_overlap;
  logic             w_capture;
  logic             w_hit_valid;

  assign w_spr_ok = (spr_draw != SPR_W'(SPR_NONE)) && (int'(spr_draw) <= INVADERS_H);
  assign w_row_ok = int'(row_sel) < INVADERS_V;
  assign w_valid  = w_spr_ok && w_row_ok;
  assign w_col    = COL_W'(spr_draw - 1'b1);
  // Index forced to 0 off-grid so the mask is never read out of range.
  assign w_idx    = w_valid ? IDX_W'(alive_idx(int'(row_sel), int'(w_col), INVADERS_H)) : '0;
  assign w_overlap = row_active && bullet_px && w_valid && r_alive[w_idx];

  invader_hit_detect_hit_fsm u_hit_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_start (frame_start),
    .i_alive_init  (alive_init),
    .i_overlap     (w_overlap),
    .i_hit_ready   (hit_ready),
    .o_capture     (w_capture),
    .o_hit_valid   (w_hit_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive       <= '1;
      r_count       <= CNT_W'(N_INV);
      r_all_dead    <= 1'b0;
      r_hit_row     <= '0;
      r_hit_col     <= '0;
      r_bullet_kill <= 1'b0;
    end else if (alive_init) begin
      r_alive       <= '1;
      r_count       <= CNT_W'(N_INV);
      r_all_dead    <= 1'b0;
      r_bullet_kill <= 1'b0;
    end else begin
      r_bullet_kill <= w_capture;
      r_all_dead    <= (r_count == '0);
      if (w_capture) begin
        r_hit_row      <= row_sel;
        r_hit_col      <= w_col;
        r_alive[w_idx] <= 1'b0;
        if (r_count != '0) r_count <= r_count - 1'b1;
      end
    end
  end

  assign hit_valid   = w_hit_valid;
  assign hit_row     = r_hit_row;
  assign hit_col     = r_hit_col;
  assign bullet_kill = r_bullet_kill;
  assign alive       = r_alive;
  assign alive_count = r_count;
  assign all_dead    = r_all_dead;

endmodule
`default_nettype wire
